// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CTRL/STATUS
// bit positions and the sequencer state encoding.
package led_seq_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd1;
  localparam logic [3:0] ADDR_MANUAL = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_IRQ_MASK = 2;
  localparam int CTRL_LAST_LSB = 8;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_IDX_LSB = 8;
  localparam int STATUS_DONE    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/led_seq_if.sv
// Bus bundle for the sequencer: Avalon-MM slave side from the Nios II
// interconnect plus the master side that drives the LED PIO s1 port.
interface led_seq_if;

  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  // Sequencer's view: register slave towards the CPU, PIO master outwards.
  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  // CPU/environment view.
  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

endinterface

// File: rtl/led_seq_timer.sv
// Loadable down-counter for the step period; holds at zero and flags it.
module led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                count <= '0;
    else if (load)            count <= value;
    else if (count != '0)     count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: register slave plus sole master of the LED PIO.
// Optional irq output is enabled by defining LED_SEQ_IRQ_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int LED_W    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic      clk,
  input  logic      reset,
  led_seq_if.slave  bus,
  output logic      busy
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic      irq
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state;
  logic                  run, oneshot;
  logic [2:0]            last;
  logic [PERIOD_W-1:0]   period;
  logic [LED_W-1:0]      manual;
  logic [LED_W-1:0]      table_mem [DEPTH];
  logic [IDX_W-1:0]      index;
  logic                  manual_pending;
  logic                  done;
`ifdef LED_SEQ_IRQ_EN
  logic                  irq_mask;
`endif

  logic                  wr, wr_ctrl, wr_period, wr_manual, wr_status, wr_table;
  logic                  run_next;
  logic [IDX_W-1:0]      last_eff, next_idx;
  logic                  timer_zero;
  logic                  unused_wdata;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
  assign wr_period = wr && (bus.address == ADDR_PERIOD);
  assign wr_manual = wr && (bus.address == ADDR_MANUAL);
  assign wr_status = wr && (bus.address == ADDR_STATUS);
  assign wr_table  = wr && bus.address[3] && (int'(bus.address[2:0]) < DEPTH);

  // Software can drop RUN at any time; the FSM reacts in the same cycle.
  assign run_next = wr_ctrl ? bus.writedata[CTRL_RUN] : run;
  assign last_eff = (int'(last) > DEPTH - 1) ? IDX_W'(DEPTH - 1) : last[IDX_W-1:0];
  assign next_idx = index + 1'b1;
  assign busy     = (state != IDLE);
  assign bus.pio_address = '0;
  assign unused_wdata    = ^bus.writedata;

  led_seq_timer #(.W(PERIOD_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state == PUSH),
    .value (period),
    .zero  (timer_zero)
  );

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so later assignments below (FSM) override the register-write defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      run                <= 1'b0;
      oneshot            <= 1'b0;
      last               <= '0;
      period             <= '0;
      manual             <= '0;
      index              <= '0;
      manual_pending     <= 1'b0;
      done               <= 1'b0;
      bus.pio_chipselect <= 1'b0;
      bus.pio_write_n    <= 1'b1;
      bus.pio_writedata  <= '0;
`ifdef LED_SEQ_IRQ_EN
      irq_mask           <= 1'b0;
`endif
      // NOTE: the pattern table is tiny and software-visible, so it is reset
      // with the rest; a large RAM would normally be left without reset.
      for (int i = 0; i < DEPTH; i++) table_mem[i] <= '0;
    end else begin
      bus.pio_chipselect <= 1'b0;
      bus.pio_write_n    <= 1'b1;

      if (wr_ctrl) begin
        run     <= bus.writedata[CTRL_RUN];
        oneshot <= bus.writedata[CTRL_ONESHOT];
        last    <= bus.writedata[CTRL_LAST_LSB +: 3];
`ifdef LED_SEQ_IRQ_EN
        irq_mask <= bus.writedata[CTRL_IRQ_MASK];
`endif
      end
      if (wr_period) period <= bus.writedata[PERIOD_W-1:0];
      if (wr_manual) begin
        manual         <= bus.writedata[LED_W-1:0];
        manual_pending <= 1'b1;
      end
      if (wr_status && bus.writedata[STATUS_DONE]) done <= 1'b0;
      if (wr_table) table_mem[bus.address[IDX_W-1:0]] <= bus.writedata[LED_W-1:0];

      case (state)
        IDLE: begin
          if (run && run_next) begin
            state              <= PUSH;
            index              <= '0;
            bus.pio_chipselect <= 1'b1;
            bus.pio_write_n    <= 1'b0;
            bus.pio_writedata  <= 32'(table_mem[0]);
          end else if (manual_pending || wr_manual) begin
            // A MANUAL write arriving now is bypassed straight to the PIO.
            bus.pio_chipselect <= 1'b1;
            bus.pio_write_n    <= 1'b0;
            bus.pio_writedata  <= wr_manual ? 32'(bus.writedata[LED_W-1:0]) : 32'(manual);
            manual_pending     <= 1'b0;
          end
        end
        PUSH: begin
          if (!run_next) begin
            state          <= IDLE;
            index          <= '0;
            manual_pending <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!run_next) begin
            state          <= IDLE;
            index          <= '0;
            manual_pending <= 1'b1;
          end else if (timer_zero) begin
            if (index < last_eff) begin
              state              <= PUSH;
              index              <= next_idx;
              bus.pio_chipselect <= 1'b1;
              bus.pio_write_n    <= 1'b0;
              bus.pio_writedata  <= 32'(table_mem[next_idx]);
            end else if (!oneshot) begin
              state              <= PUSH;
              index              <= '0;
              bus.pio_chipselect <= 1'b1;
              bus.pio_write_n    <= 1'b0;
              bus.pio_writedata  <= 32'(table_mem[0]);
            end else begin
              state          <= IDLE;
              run            <= 1'b0;
              done           <= 1'b1;
              manual_pending <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: readdata gets a default before the decode so no latch is inferred.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        bus.readdata[CTRL_RUN]            = run;
        bus.readdata[CTRL_ONESHOT]        = oneshot;
        bus.readdata[CTRL_LAST_LSB +: 3]  = last;
`ifdef LED_SEQ_IRQ_EN
        bus.readdata[CTRL_IRQ_MASK]       = irq_mask;
`endif
      end
      ADDR_PERIOD: bus.readdata[PERIOD_W-1:0] = period;
      ADDR_MANUAL: bus.readdata[LED_W-1:0]    = manual;
      ADDR_STATUS: begin
        bus.readdata[STATUS_BUSY]          = busy;
        bus.readdata[STATUS_IDX_LSB +: 3]  = 3'(index);
        bus.readdata[STATUS_DONE]          = done;
      end
      default: begin
        if (bus.address[3] && (int'(bus.address[2:0]) < DEPTH))
          bus.readdata[LED_W-1:0] = table_mem[bus.address[IDX_W-1:0]];
      end
    endcase
  end

`ifdef LED_SEQ_IRQ_EN
  assign irq = done & irq_mask;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: register vectors, directed sequences
// and randomized runs scored against a schedule-level reference model.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

`ifdef LED_SEQ_IRQ_EN
  localparam int IRQ_BIT = 4;
`else
  localparam int IRQ_BIT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef LED_SEQ_IRQ_EN
  logic irq;
`endif

  led_seq_if bus ();

  led_seq_ctrl #(.DEPTH(8), .LED_W(8), .PERIOD_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } pw_t;

  pw_t mon_q[$];
  pw_t exp_q[$];

  always @(negedge clk)
    if (!reset && bus.pio_chipselect && !bus.pio_write_n)
      mon_q.push_back('{cyc, bus.pio_writedata});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.address    = '0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    step();
    bus.address = '0;
  endtask

  // Expected PIO writes derived from the timing rules: first write two cycles
  // after the RUN write, then one every PERIOD+2 cycles cycling through
  // entries 0..LAST; a stop (oneshot end or RUN cleared) restores MANUAL.
  logic [7:0] tbl [8];

  function automatic void build_expected(input int n_run, input int period, input int last,
                                         input bit oneshot, input logic [7:0] man,
                                         input int clear_cyc);
    int t, k;
    exp_q.delete();
    t = n_run + 2;
    k = 0;
    while (1) begin
      if (!oneshot && t > clear_cyc) begin
        exp_q.push_back('{clear_cyc + 2, 32'(man)});
        break;
      end
      exp_q.push_back('{t, 32'(tbl[k % (last + 1)])});
      if (oneshot && (k % (last + 1)) == last) begin
        exp_q.push_back('{t + period + 3, 32'(man)});
        break;
      end
      k++;
      t += period + 2;
    end
  endfunction

  task automatic run_case(input string tag, input int period, input int last, input bit oneshot,
                          input logic [7:0] man, input int clear_off);
    int          n, clr;
    logic [31:0] got;
    for (int i = 0; i < 8; i++) bus_write(4'(8 + i), 32'(tbl[i]));
    bus_write(ADDR_PERIOD, 32'(period));
    bus_write(ADDR_MANUAL, 32'(man));
    idle(2);
    bus_write(ADDR_STATUS, 32'h0001_0000);
    mon_q.delete();
    n = cyc;
    bus_write(ADDR_CTRL, 32'((last << 8) | (int'(oneshot) << 1) | IRQ_BIT | 1));
    clr = oneshot ? -1 : n + clear_off;
    build_expected(n, period, last, oneshot, man, clr);
    if (!oneshot) begin
      while (cyc < clr) step();
      bus_write(ADDR_CTRL, 32'(last << 8));
      check({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
      rd_reg(ADDR_STATUS, got);
      check({tag, "_index_after_stop"}, (got >> 8) & 32'h7, 32'd0);
    end
    while (cyc < exp_q[$].cyc + 3) step();
    check({tag, "_write_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check($sformatf("%s_w%0d_cycle", tag, i), 32'(mon_q[i].cyc), 32'(exp_q[i].cyc));
      check($sformatf("%s_w%0d_data", tag, i), mon_q[i].data, exp_q[i].data);
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic        cs;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] got;
    int          n;

    vecs[0] = '{ADDR_PERIOD, 1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[1] = '{ADDR_PERIOD, 1'b0, 32'h0000_1234, 32'h00FF_FFFF};
    vecs[2] = '{ADDR_MANUAL, 1'b1, 32'h0000_12C3, 32'h0000_00C3};
    vecs[3] = '{ADDR_CTRL,   1'b1, 32'h0000_0F06, 32'h0000_0702 | IRQ_BIT};
    vecs[4] = '{4'd4,        1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5] = '{4'd7,        1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[6] = '{4'd9,        1'b1, 32'h0000_ABCD, 32'h0000_00CD};
    vecs[7] = '{4'd15,       1'b1, 32'h0000_005A, 32'h0000_005A};
    vecs[8] = '{ADDR_STATUS, 1'b1, 32'hFFFE_FFFF, 32'h0000_0000};
    vecs[9] = '{ADDR_CTRL,   1'b1, 32'h0000_0000, 32'h0000_0000};

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    // Quiet after reset: no PIO traffic, every register reads zero.
    mon_q.delete();
    idle(20);
    check("idle_pio_writes", 32'(mon_q.size()), 32'd0);
    check("idle_pio_write_n", 32'(bus.pio_write_n), 32'd1);
    check("idle_pio_cs", 32'(bus.pio_chipselect), 32'd0);
    check("idle_pio_addr", 32'(bus.pio_address), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd_reg(4'(a), got);
      check($sformatf("reset_read_addr%0d", a), got, 32'd0);
    end

    // MANUAL while idle reaches the PIO exactly one cycle later.
    mon_q.delete();
    n = cyc;
    bus_write(ADDR_MANUAL, 32'h0000_00A5);
    idle(4);
    check("manual_count", 32'(mon_q.size()), 32'd1);
    if (mon_q.size() > 0) begin
      check("manual_cycle", 32'(mon_q[0].cyc), 32'(n + 1));
      check("manual_data", mon_q[0].data, 32'h0000_00A5);
    end

    // Register map vectors.
    foreach (vecs[i]) begin
      if (vecs[i].cs) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus.address = vecs[i].addr; bus.write_n = 1'b0; bus.writedata = vecs[i].wdata;
        step();
        bus.write_n = 1'b1; bus.writedata = '0;
      end
      rd_reg(vecs[i].addr, got);
      check($sformatf("regvec%0d_addr%0d", i, vecs[i].addr), got, vecs[i].exp);
    end
    idle(3);

    // Continuous 01,02,04,08 at PERIOD=3, stopped mid-WAIT on index 2.
    for (int i = 0; i < 8; i++) tbl[i] = 8'(1 << (i % 4));
    run_case("loop_stop", 3, 3, 1'b0, 8'h3C, 34);

    // Oneshot ends with DONE set and MANUAL restored.
    run_case("oneshot", 3, 3, 1'b1, 8'h55, 0);
    rd_reg(ADDR_STATUS, got);
    check("oneshot_done", got & 32'h0001_0001, 32'h0001_0000);
    rd_reg(ADDR_CTRL, got);
    check("oneshot_run_cleared", got & 32'h1, 32'd0);
`ifdef LED_SEQ_IRQ_EN
    check("oneshot_irq_set", 32'(irq), 32'd1);
`endif
    bus_write(ADDR_STATUS, 32'h0001_0000);
    rd_reg(ADDR_STATUS, got);
    check("done_cleared", got & 32'h0001_0000, 32'd0);
`ifdef LED_SEQ_IRQ_EN
    check("irq_cleared", 32'(irq), 32'd0);
`endif

    // Randomized runs, including PERIOD=0 and LAST=0 corners.
    for (int it = 0; it < 8; it++) begin
      int  p, l;
      bit  os;
      for (int i = 0; i < 8; i++) tbl[i] = 8'($urandom);
      p  = (it == 0) ? 0 : int'($urandom_range(0, 4));
      l  = (it == 1) ? 0 : int'($urandom_range(0, 7));
      os = bit'($urandom_range(0, 1));
      run_case($sformatf("rand%0d", it), p, l, os, 8'($urandom),
               2 + int'($urandom_range(0, (l + 1) * (p + 2) + 3)));
    end

    // Reset in the middle of a running sequence.
    for (int i = 0; i < 8; i++) tbl[i] = 8'(8'h11 * (i + 1));
    bus_write(4'd8, 32'h0000_0011);
    bus_write(ADDR_PERIOD, 32'd3);
    bus_write(ADDR_CTRL, 32'h0000_0301);
    idle(9);
    reset = 1'b1;
    step();
    check("rst_pio_cs", 32'(bus.pio_chipselect), 32'd0);
    check("rst_pio_write_n", 32'(bus.pio_write_n), 32'd1);
    check("rst_pio_wdata", bus.pio_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    mon_q.delete();
    idle(15);
    check("rst_no_pio_after", 32'(mon_q.size()), 32'd0);
    rd_reg(ADDR_CTRL, got);
    check("rst_ctrl_zero", got, 32'd0);
    rd_reg(4'd8, got);
    check("rst_table0_zero", got, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
